// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus a transmit sequencer that feeds a UART
// transmitter on the same clock. Bytes are popped one at a time into tx_din,
// tx_enable is raised until the transmitter reports sending, and a one-cycle
// gap with enable low separates consecutive bytes.
module uart_tx_fifo #(
   parameter int DEPTH         = 16,
   parameter int ADDR_W        = 4,
   parameter int START_TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              start_err,
   output logic              busy,
   output logic [7:0]        tx_din,
   output logic              tx_enable,
   input  logic              tx_sending
);

   // Timeout counter only needs to reach START_TIMEOUT-1.
   localparam int                TMO_W    = $clog2(START_TIMEOUT);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(START_TIMEOUT - 1);
   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ASSERT    = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_GAP       = 2'd3
   } state_t;

   logic [7:0]        mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              overflow_q, overflow_d;
   logic              start_err_q, start_err_d;
   logic              busy_q, busy_d;
   logic              tx_en_q, tx_en_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [7:0]        tx_din_q;

   logic              wr_accept;
   logic              pop;

   // Full/empty are registered, so acceptance and pop decisions use the
   // pre-edge occupancy; a write into an empty FIFO is not popped that cycle.
   assign wr_accept = reset && wr_en && !full_q;
   assign pop       = reset && (state_q == S_IDLE) && !empty_q;

   // Storage array: write port only, contents need no reset since the
   // pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   // Registered read port: the popped byte lands directly in tx_din and is
   // held there until the next pop.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_din_q <= 8'h00;
      end else if (pop) begin
         tx_din_q <= mem[rd_ptr_q];
      end
   end

   // Next-state logic for pointers, occupancy, flags and the sequencer.
   always_comb begin
      state_d     = state_q;
      tx_en_d     = tx_en_q;
      tmo_d       = tmo_q;
      start_err_d = 1'b0;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end

      case ({wr_accept, pop})
         2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
         2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (!empty_q) begin
               state_d = S_ASSERT;
               tx_en_d = 1'b1;
               tmo_d   = '0;
            end
         end
         S_ASSERT: begin
            if (tx_sending) begin
               tx_en_d = 1'b0;
               state_d = S_WAIT_DONE;
            end else if (tmo_q == TMO_LAST) begin
               // Transmitter never started: drop the byte, no retry.
               tx_en_d     = 1'b0;
               start_err_d = 1'b1;
               state_d     = S_GAP;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (!tx_sending) begin
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            tx_en_d = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            tx_en_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      full_d     = (count_d == FULL_CNT);
      empty_d    = (count_d == '0);
      overflow_d = wr_en && full_q;
      busy_d     = (state_d != S_IDLE);
   end

   // State register with synchronous active-low reset; reset flushes the FIFO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         start_err_q <= 1'b0;
         busy_q      <= 1'b0;
         tx_en_q     <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         overflow_q  <= overflow_d;
         start_err_q <= start_err_d;
         busy_q      <= busy_d;
         tx_en_q     <= tx_en_d;
         tmo_q       <= tmo_d;
      end
   end

   assign full      = full_q;
   assign empty     = empty_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign start_err = start_err_q;
   assign busy      = busy_q;
   assign tx_din    = tx_din_q;
   assign tx_enable = tx_en_q;

endmodule
